// File: rtl/taylor_result_buffer.sv
// Output buffer behind the last Taylor-series pipe stage.
// Holds results in a show-ahead FIFO and hands them out on a valid/ready handshake.
// Stalls the pipe while the FIFO is full.
// Tracks a sticky error for incomplete samples and wrapping result/overflow counters.
module taylor_result_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_occ,
    input  logic [WIDTH-1:0]         in_y,
    input  logic                     in_ovf,
    input  logic                     in_valid,
    output logic                     stall_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic                     out_ovf,
    output logic                     out_incomplete,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     sticky_clr,
    output logic                     err_sticky,
    output logic [CNT_W-1:0]         res_cnt,
    output logic [CNT_W-1:0]         ovf_cnt
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W  = ADDR_W + 1;
    localparam int unsigned ENT_W  = WIDTH + 2;

    // Entry layout: {y, ovf, incomplete}
    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0]  r_count;
    logic              r_err_sticky;
    logic [CNT_W-1:0]  r_res_cnt;
    logic [CNT_W-1:0]  r_ovf_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_in_incomplete;
    logic [ENT_W-1:0]  w_head;

    assign w_full          = (r_count == OCC_W'(DEPTH));
    assign w_empty         = (r_count == '0);
    // A refused push holds upstream, so full alone gates it even if a pop happens now.
    assign w_push          = in_occ & ~w_full;
    assign w_pop           = ~w_empty & out_ready;
    assign w_in_incomplete = in_occ & ~in_valid & ~in_ovf;
    assign w_head          = r_mem[r_rd_ptr];

    assign stall_out      = w_full;
    assign out_valid      = ~w_empty;
    assign out_y          = w_empty ? '0 : w_head[ENT_W-1:2];
    assign out_ovf        = w_empty ? 1'b0 : w_head[1];
    assign out_incomplete = w_empty ? 1'b0 : w_head[0];
    assign count          = r_count;
    assign err_sticky     = r_err_sticky;
    assign res_cnt        = r_res_cnt;
    assign ovf_cnt        = r_ovf_cnt;

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_y, in_ovf, w_in_incomplete};
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Statistics; a clear wins over a same-cycle push, which is then stored but not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_res_cnt    <= '0;
            r_ovf_cnt    <= '0;
        end else if (sticky_clr) begin
            r_err_sticky <= 1'b0;
            r_res_cnt    <= '0;
            r_ovf_cnt    <= '0;
        end else if (w_push) begin
            r_err_sticky <= r_err_sticky | w_in_incomplete;
            r_res_cnt    <= r_res_cnt + CNT_W'(1);
            r_ovf_cnt    <= r_ovf_cnt + CNT_W'(in_ovf);
        end
    end

endmodule

// File: tb/tb_taylor_result_buffer.sv
// Directed bench for taylor_result_buffer (DEPTH=4, reduced CNT_W=4 so wrap is cheap).
module tb_taylor_result_buffer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_occ;
    logic [WIDTH-1:0] in_y;
    logic             in_ovf;
    logic             in_valid;
    logic             stall_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_ovf;
    logic             out_incomplete;
    logic [2:0]       count;
    logic             sticky_clr;
    logic             err_sticky;
    logic [CNT_W-1:0] res_cnt;
    logic [CNT_W-1:0] ovf_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    taylor_result_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .in_occ         (in_occ),
        .in_y           (in_y),
        .in_ovf         (in_ovf),
        .in_valid       (in_valid),
        .stall_out      (stall_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_y          (out_y),
        .out_ovf        (out_ovf),
        .out_incomplete (out_incomplete),
        .count          (count),
        .sticky_clr     (sticky_clr),
        .err_sticky     (err_sticky),
        .res_cnt        (res_cnt),
        .ovf_cnt        (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        in_occ     = 1'b0;
        in_y       = '0;
        in_ovf     = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_stall", 64'(stall_out), 64'd0);
        check("rst_y", 64'(out_y), 64'd0);
        check("rst_err", 64'(err_sticky), 64'd0);
        check("rst_res", 64'(res_cnt), 64'd0);
        check("rst_ovfc", 64'(ovf_cnt), 64'd0);

        // Single push, visible next cycle, then popped
        in_occ = 1'b1; in_y = 32'h0123_4567; in_valid = 1'b1; in_ovf = 1'b0;
        step();
        in_occ = 1'b0;
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_y", 64'(out_y), 64'h0123_4567);
        check("t1_ovf", 64'(out_ovf), 64'd0);
        check("t1_count", 64'(count), 64'd1);
        check("t1_res", 64'(res_cnt), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t1_pop_valid", 64'(out_valid), 64'd0);
        check("t1_pop_y", 64'(out_y), 64'd0);
        check("t1_pop_count", 64'(count), 64'd0);

        // Fill to full, refused fifth sample, pop while full does not admit it
        for (int i = 1; i <= 4; i++) begin
            in_occ = 1'b1; in_y = 32'(i); in_valid = 1'b1;
            step();
        end
        check("t2_full_count", 64'(count), 64'd4);
        check("t2_stall", 64'(stall_out), 64'd1);
        in_y = 32'd5;
        step();
        check("t2_refused_count", 64'(count), 64'd4);
        check("t2_refused_res", 64'(res_cnt), 64'd5);
        check("t2_head", 64'(out_y), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t2_popfull_count", 64'(count), 64'd3);
        check("t2_popfull_res", 64'(res_cnt), 64'd5);
        check("t2_popfull_stall", 64'(stall_out), 64'd0);
        step();
        in_occ = 1'b0;
        check("t2_accept_count", 64'(count), 64'd4);
        check("t2_accept_res", 64'(res_cnt), 64'd6);
        out_ready = 1'b1;
        for (int e = 2; e <= 5; e++) begin
            check($sformatf("t2_drain_valid%0d", e), 64'(out_valid), 64'd1);
            check($sformatf("t2_drain_y%0d", e), 64'(out_y), 64'(e));
            step();
        end
        out_ready = 1'b0;
        check("t2_drained", 64'(count), 64'd0);

        // Streaming: one in, one out per cycle, pointers wrap
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_occ = 1'b1; in_y = 32'(10 + k); in_valid = 1'b1;
            step();
            check($sformatf("t3_y%0d", k), 64'(out_y), 64'(10 + k));
            check($sformatf("t3_count%0d", k), 64'(count), 64'd1);
            check($sformatf("t3_stall%0d", k), 64'(stall_out), 64'd0);
        end
        in_occ = 1'b0;
        step();
        out_ready = 1'b0;
        check("t3_empty", 64'(count), 64'd0);
        // 6 + 10 pushes wraps a 4-bit counter to 0
        check("t3_res_wrap", 64'(res_cnt), 64'd0);

        // Overflow then incomplete arrival
        in_occ = 1'b1; in_y = 32'h8000_0000; in_ovf = 1'b1; in_valid = 1'b0;
        step();
        in_y = 32'h0000_00AA; in_ovf = 1'b0; in_valid = 1'b0;
        check("t4_ovf_head", 64'(out_ovf), 64'd1);
        check("t4_ovf_inc", 64'(out_incomplete), 64'd0);
        check("t4_ovf_y", 64'(out_y), 64'h8000_0000);
        check("t4_ovfc", 64'(ovf_cnt), 64'd1);
        check("t4_err0", 64'(err_sticky), 64'd0);
        step();
        in_occ = 1'b0;
        check("t4_count", 64'(count), 64'd2);
        check("t4_err1", 64'(err_sticky), 64'd1);
        check("t4_res", 64'(res_cnt), 64'd2);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("t4_clr_err", 64'(err_sticky), 64'd0);
        check("t4_clr_res", 64'(res_cnt), 64'd0);
        check("t4_clr_ovfc", 64'(ovf_cnt), 64'd0);
        check("t4_clr_count", 64'(count), 64'd2);
        check("t4_clr_head", 64'(out_y), 64'h8000_0000);
        out_ready = 1'b1;
        step();
        check("t4_inc_y", 64'(out_y), 64'h0000_00AA);
        check("t4_inc_flag", 64'(out_incomplete), 64'd1);
        check("t4_inc_ovf", 64'(out_ovf), 64'd0);
        step();
        out_ready = 1'b0;
        check("t4_empty", 64'(count), 64'd0);

        // Clear coincident with a push: stored, not counted
        sticky_clr = 1'b1; in_occ = 1'b1; in_y = 32'h55; in_ovf = 1'b1; in_valid = 1'b0;
        step();
        sticky_clr = 1'b0; in_occ = 1'b0; in_ovf = 1'b0;
        check("t4b_res", 64'(res_cnt), 64'd0);
        check("t4b_ovfc", 64'(ovf_cnt), 64'd0);
        check("t4b_count", 64'(count), 64'd1);
        check("t4b_y", 64'(out_y), 64'h55);
        check("t4b_ovf", 64'(out_ovf), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Counter wrap: 16 counted pushes on a 4-bit counter
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            in_occ = 1'b1; in_y = 32'(k); in_valid = 1'b1;
            step();
            if (k == 15) check("t5_res15", 64'(res_cnt), 64'd15);
        end
        in_occ = 1'b0;
        check("t5_res_wrap", 64'(res_cnt), 64'd0);
        step();
        out_ready = 1'b0;

        // Asynchronous reset mid-operation
        for (int k = 0; k < 3; k++) begin
            in_occ = 1'b1; in_y = 32'(32'h100 + k); in_valid = 1'b1;
            step();
        end
        in_occ = 1'b0;
        check("t6_pre_count", 64'(count), 64'd3);
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_valid", 64'(out_valid), 64'd0);
        check("t6_async_count", 64'(count), 64'd0);
        check("t6_async_stall", 64'(stall_out), 64'd0);
        check("t6_async_y", 64'(out_y), 64'd0);
        step();
        rst = 1'b0;
        in_occ = 1'b1; in_y = 32'd7; in_valid = 1'b1;
        step();
        in_occ = 1'b0;
        check("t6_new_count", 64'(count), 64'd1);
        check("t6_new_y", 64'(out_y), 64'd7);
        check("t6_new_res", 64'(res_cnt), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t6_sole", 64'(count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/taylor_result_buffer.md
Name: taylor_result_buffer

Overview:
- Output stage directly downstream of the last Taylor-series pipe stage.
- Captures the final accumulator `y`, the overflow flag and the completion flag into a small show-ahead FIFO.
- Presents results to the consumer over a valid/ready handshake.
- Back-pressures the pipeline with a stall when full, and keeps sticky error status plus result/overflow statistics counters.

Parameters:
- WIDTH, 32, width of result word `y` (matches pipe accumulator)
- DEPTH, 4, FIFO entries; power of two, >= 2
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_occ  in  1  last pipe slot holds a live sample this cycle
- in_y  in  WIDTH  final accumulator from last pipe stage
- in_ovf  in  1  overflow flag from last pipe stage
- in_valid  in  1  completion flag from last pipe stage (term counter reached zero, no overflow)
- stall_out  out  1  freeze pipeline; upstream holds in_* stable while high
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_y  out  WIDTH  head result
- out_ovf  out  1  head entry overflowed
- out_incomplete  out  1  head entry arrived with in_valid=0 and in_ovf=0
- count  out  log2(DEPTH)+1  current occupancy
- sticky_clr  in  1  synchronous clear of err_sticky and both counters
- err_sticky  out  1  set on any incomplete arrival
- res_cnt  out  CNT_W  results accepted since reset/clear, wraps
- ovf_cnt  out  CNT_W  accepted results with ovf=1, wraps

Behaviour:
- Reset (async, immediate, also mid-transfer): wr_ptr, rd_ptr and count go to 0; out_valid=0, out_y=0, out_ovf=0, out_incomplete=0, stall_out=0, err_sticky=0, res_cnt=0, ovf_cnt=0. Stored memory contents need not be cleared.
- Push: push = in_occ & ~full. On the clock edge, write {in_y, in_ovf, in_incomplete} at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
  - in_incomplete = in_occ & ~in_valid & ~in_ovf.
  - An overflowed sample is stored with ovf=1 regardless of in_valid.
- Pop: pop = out_valid & out_ready. Advances rd_ptr, with wrap. A pop while empty is impossible because out_valid=0.
- Latency: a pushed entry is visible on out_* the next cycle when the FIFO was empty (show-ahead; out_* driven from mem[rd_ptr]).
- When out_valid=0, out_y/out_ovf/out_incomplete are forced to 0.
- Occupancy: full = (count == DEPTH); empty = (count == 0).
  - Simultaneous push and pop: count unchanged, both pointers advance.
- stall_out = full, decoded from registers only; no combinational path from out_ready.
  - When full, a push is refused even if a pop occurs the same cycle. The sample is held upstream and accepted the next cycle.
- in_occ=0: no push, no counter or flag change; in_y, in_ovf and in_valid are ignored.
- Statistics (per push):
  - res_cnt += 1.
  - ovf_cnt += in_ovf.
  - err_sticky |= in_incomplete.
  - Both counters wrap at 2^CNT_W.
- sticky_clr takes priority over a same-cycle increment: the counters become 0 and err_sticky becomes 0.
  - A push in the same cycle is still stored in the FIFO but is not counted.
- Data integrity: entries come out in arrival order, bit-exact, across pointer wrap.

Test Plan:
- Reset, then one push: in_occ=1, in_y=32'h0123_4567, in_valid=1, in_ovf=0 -> next cycle out_valid=1, out_y=32'h0123_4567, out_ovf=0, count=1, res_cnt=1; out_ready=1 for one cycle -> out_valid=0, out_y=0, count=0.
- Fill DEPTH=4 with y=1,2,3,4 and out_ready=0 -> count=4, stall_out=1. A fifth sample (y=5) held with in_occ=1 stays refused, and res_cnt stays 4. Pop once -> y=5 accepted the following cycle, and drain order is 1,2,3,4,5.
- Streaming with in_occ=1 and out_ready=1 every cycle for 10 samples (y=10..19) -> count stays <=1, outputs in order 10..19, pointers wrap twice, stall_out never asserted.
- Overflow and incomplete arrivals: in_ovf=1, in_valid=0 (y=32'h8000_0000) -> out_ovf=1, out_incomplete=0, ovf_cnt=1. Then in_ovf=0, in_valid=0 -> out_incomplete=1, err_sticky=1. Then sticky_clr -> err_sticky=0, res_cnt=0, ovf_cnt=0, with FIFO contents intact.
- Counter wrap: preload by pushing 2^CNT_W samples (or use a reduced CNT_W=4 build and push 16) -> res_cnt returns to 0.
- Reset mid-operation: with count=3 and out_valid=1, assert rst asynchronously between clock edges -> out_valid=0, count=0, stall_out=0 immediately. After release, a new push with y=7 appears as the sole entry.
